// File: rtl/keypad_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : keypad_tone_gen
// Description : Square-wave tone generator driven by the keypad encoder.
//               A 4-bit keycode selects one of 13 notes (C4..C5), a one-cycle
//               mode pulse steps the octave shift (0..3, wrapping), and a
//               one-cycle sound pulse toggles mute. The half-period table is
//               computed at elaboration from CLK_HZ.
//
// Ports       : clk          system clock, rising edge
//               rst          synchronous active-high reset
//               keycode[3:0] 0..12 = note C4..C5, 13..15 = no key
//               mode_edge    one-cycle pulse, advance octave
//               sound_edge   one-cycle pulse, toggle mute
//               tone_out     registered square wave
//               note_active  registered: valid note held and not muted
//               octave[1:0]  current octave shift
//               muted        current mute state
//
// Revision    : 1.0  initial release
// ============================================================================
module keypad_tone_gen #(
    parameter int CLK_HZ = 10_000_000,
    parameter int DIV_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keycode,
    input  logic       mode_edge,
    input  logic       sound_edge,
    output logic       tone_out,
    output logic       note_active,
    output logic [1:0] octave,
    output logic       muted
);

    localparam int         c_num_notes = 13;
    localparam logic [3:0] c_key_idle  = 4'hF;

    // Note frequencies in centi-Hz, C4 .. C5.
    function automatic logic [63:0] f_freq(input int k);
        logic [63:0] v;
        case (k)
            0:       v = 64'd26163;
            1:       v = 64'd27718;
            2:       v = 64'd29366;
            3:       v = 64'd31113;
            4:       v = 64'd32963;
            5:       v = 64'd34923;
            6:       v = 64'd36999;
            7:       v = 64'd39200;
            8:       v = 64'd41530;
            9:       v = 64'd44000;
            10:      v = 64'd46616;
            11:      v = 64'd49388;
            12:      v = 64'd52325;
            default: v = 64'd26163;
        endcase
        return v;
    endfunction

    // Rounded half-period in clock cycles: (CLK_HZ*100 + F) / (2*F).
    function automatic logic [63:0] f_half_period(input int k);
        return (64'(CLK_HZ) * 64'd100 + f_freq(k)) / (64'd2 * f_freq(k));
    endfunction

    // ------------------------------------------------------------------------
    // Half-period lookup table, indexed directly by the registered keycode.
    // Entries 13..15 are idle codes and never used for counting.
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] w_tab [0:15];

    generate
        for (genvar g = 0; g < 16; g++) begin : g_tab
            if (g < c_num_notes) begin : g_note
                localparam logic [63:0] c_hp = f_half_period(g);
                if (c_hp >= (64'd1 << DIV_W)) begin : g_overflow
                    $error("keypad_tone_gen: half-period table entry does not fit DIV_W");
                end
                assign w_tab[g] = c_hp[DIV_W-1:0];
            end else begin : g_none
                assign w_tab[g] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [3:0]       r_key_q;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tone;
    logic [1:0]       r_octave;
    logic             r_muted;
    logic             r_tone_out;
    logic             r_note_active;

    logic             w_key_valid;
    logic             w_restart;
    logic [DIV_W-1:0] w_hp_base;
    logic [DIV_W-1:0] w_hp_shift;
    logic [DIV_W-1:0] w_hp;
    logic             w_wrap;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_tone_nxt;
    logic [1:0]       w_octave_nxt;
    logic             w_muted_nxt;

    assign w_key_valid = (r_key_q < 4'(c_num_notes));

    // A new keycode or an octave step restarts the waveform from a low phase.
    // Re-presenting the same keycode is not a change and does not restart.
    assign w_restart = (keycode != r_key_q) | mode_edge;

    // Octave shift halves the half-period; floor at 2 so the wave never
    // degenerates into a constant level.
    assign w_hp_base  = w_tab[r_key_q];
    assign w_hp_shift = w_hp_base >> r_octave;
    assign w_hp       = (w_hp_shift < DIV_W'(2)) ? DIV_W'(2) : w_hp_shift;
    assign w_wrap     = (r_cnt == (w_hp - DIV_W'(1)));

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_tone_nxt = r_tone;
        if (w_restart || !w_key_valid) begin
            w_cnt_nxt  = '0;
            w_tone_nxt = 1'b0;
        end else if (w_wrap) begin
            w_cnt_nxt  = '0;
            w_tone_nxt = ~r_tone;
        end else begin
            w_cnt_nxt  = r_cnt + DIV_W'(1);
        end
    end

    assign w_octave_nxt = mode_edge  ? (r_octave + 2'd1) : r_octave;
    assign w_muted_nxt  = sound_edge ? ~r_muted          : r_muted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_q       <= c_key_idle;
            r_cnt         <= '0;
            r_tone        <= 1'b0;
            r_octave      <= 2'd0;
            r_muted       <= 1'b0;
            r_tone_out    <= 1'b0;
            r_note_active <= 1'b0;
        end else begin
            r_key_q       <= keycode;
            r_cnt         <= w_cnt_nxt;
            r_tone        <= w_tone_nxt;
            r_octave      <= w_octave_nxt;
            r_muted       <= w_muted_nxt;
            // Mute only gates the pin; the internal tone keeps running so an
            // unmute lands back on the undisturbed phase.
            r_tone_out    <= w_tone_nxt & ~w_muted_nxt;
            // Status reflects the already-registered key and mute state.
            r_note_active <= w_key_valid & ~r_muted;
        end
    end

    assign tone_out    = r_tone_out;
    assign note_active = r_note_active;
    assign octave      = r_octave;
    assign muted       = r_muted;

endmodule
`default_nettype wire
